// File: rtl/text_console_pkg.sv
// -----------------------------------------------------------------------------
// text_console_pkg
// Shared definitions for the text console generator:
//   - ASCII codes with special meaning on the character port
//   - controller FSM state encoding
//   - tile geometry and tile RAM address width
//   - is_printable(): true for codes that are stored in the tile RAM
// No ports (package).
// -----------------------------------------------------------------------------
package text_console_pkg;

    localparam logic [6:0] CHR_SPACE = 7'h20;
    localparam logic [6:0] CHR_BS    = 7'h08;
    localparam logic [6:0] CHR_LF    = 7'h0A;
    localparam logic [6:0] CHR_CR    = 7'h0D;
    localparam logic [6:0] CHR_MIN   = 7'h20;
    localparam logic [6:0] CHR_MAX   = 7'h7E;

    localparam int TILE_W = 8;
    localparam int TILE_H = 16;
    localparam int RAM_AW = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= CHR_MIN) && (c <= CHR_MAX);
    endfunction

endpackage

// File: rtl/text_console_gen_if.sv
// -----------------------------------------------------------------------------
// text_console_gen_if
// Valid/ready character port of the text console.
//   char_valid : source offers a character
//   char_data  : 7-bit ASCII code
//   char_ready : console accepts the character this cycle (valid & ready)
// Modports: master = character source, slave = console.
// -----------------------------------------------------------------------------
interface text_console_gen_if;
    logic       char_valid;
    logic [6:0] char_data;
    logic       char_ready;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/ascii_rom.sv
// -----------------------------------------------------------------------------
// ascii_rom
// 8x16 glyph ROM with a registered output.
//   clk  : clock
//   addr : {ascii_code[6:0], glyph_row[3:0]}
//   data : glyph row, bit 7 is the leftmost pixel; valid one cycle after addr
// Codes without a table entry render as blank rows (space included).
// -----------------------------------------------------------------------------
module ascii_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    function automatic logic [7:0] glyph(input logic [10:0] a);
        logic [7:0] g;
        g = 8'h00;
        case (a)
            // 'A'
            11'h412: g = 8'h10;  11'h413: g = 8'h38;  11'h414: g = 8'h6C;
            11'h415: g = 8'hC6;  11'h416: g = 8'hC6;  11'h417: g = 8'hFE;
            11'h418: g = 8'hC6;  11'h419: g = 8'hC6;  11'h41A: g = 8'hC6;
            11'h41B: g = 8'hC6;
            // 'B'
            11'h422: g = 8'hFC;  11'h423: g = 8'h66;  11'h424: g = 8'h66;
            11'h425: g = 8'h66;  11'h426: g = 8'h7C;  11'h427: g = 8'h66;
            11'h428: g = 8'h66;  11'h429: g = 8'h66;  11'h42A: g = 8'h66;
            11'h42B: g = 8'hFC;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk) begin
        data <= glyph(addr);
    end

endmodule

// File: rtl/console_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// console_cursor_ctrl
// Cursor position registers and wrap arithmetic for a COLS x ROWS console.
//   clk, reset : clock, asynchronous active-high reset (cursor -> (0,0))
//   home       : go to (0,0)                      (highest priority)
//   advance    : next cell, row carry, wraps (COLS-1,ROWS-1) -> (0,0)
//   right      : same as advance
//   back       : previous cell, (0,cy) -> (COLS-1,cy-1), stays at (0,0)
//   newline    : column 0 of the next row, last row wraps to row 0
//   left/up/down : single-axis moves, each axis wraps on its own
//   cx, cy     : current cursor
//   nx, ny     : cursor after this cycle's command
//   moved      : the command changes the cursor position
// -----------------------------------------------------------------------------
module console_cursor_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       home,
    input  logic       advance,
    input  logic       right,
    input  logic       back,
    input  logic       newline,
    input  logic       left,
    input  logic       up,
    input  logic       down,
    output logic [6:0] cx,
    output logic [4:0] cy,
    output logic [6:0] nx,
    output logic [4:0] ny,
    output logic       moved
);

    localparam logic [6:0] CX_MAX = 7'(COLS - 1);
    localparam logic [4:0] CY_MAX = 5'(ROWS - 1);

    // The top level presents at most one command class per cycle; the order
    // here only matters for simultaneous arrow pulses.
    always_comb begin
        nx = cx;
        ny = cy;
        if (home) begin
            nx = 7'd0;
            ny = 5'd0;
        end else if (advance || right) begin
            if (cx == CX_MAX) begin
                nx = 7'd0;
                ny = (cy == CY_MAX) ? 5'd0 : cy + 5'd1;
            end else begin
                nx = cx + 7'd1;
            end
        end else if (back) begin
            if (cx != 7'd0) begin
                nx = cx - 7'd1;
            end else if (cy != 5'd0) begin
                nx = CX_MAX;
                ny = cy - 5'd1;
            end
        end else if (newline) begin
            nx = 7'd0;
            ny = (cy == CY_MAX) ? 5'd0 : cy + 5'd1;
        end else if (left) begin
            nx = (cx == 7'd0) ? CX_MAX : cx - 7'd1;
        end else if (up) begin
            ny = (cy == 5'd0) ? CY_MAX : cy - 5'd1;
        end else if (down) begin
            ny = (cy == CY_MAX) ? 5'd0 : cy + 5'd1;
        end
    end

    assign moved = (nx != cx) || (ny != cy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx <= 7'd0;
            cy <= 5'd0;
        end else begin
            cx <= nx;
            cy <= ny;
        end
    end

endmodule

// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
// Simple dual-port RAM: one synchronous write port, one registered read port.
//   clk    : clock
//   we     : write enable (port A)
//   addr_a : write address,  din_a : write data
//   addr_b : read address,   dout_b: read data, one cycle after addr_b
// No reset; contents are undefined until written.
// -----------------------------------------------------------------------------
module dual_port_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr_a] <= din_a;
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/text_console_gen.sv
// -----------------------------------------------------------------------------
// text_console_gen
// COLS x ROWS character console of 8x16 tiles on a 640x480 pixel stream.
//   clk, reset        : clock, asynchronous active-high reset
//   video_on, x, y    : pixel position from the sync counter
//   cif (slave)       : valid/ready character port (char_valid/data/ready)
//   up/down/left/right: single-cycle cursor move pulses
//   clr_req           : single-cycle clear-screen request
//   busy              : clear engine running
//   rgb               : pixel colour for (x, y, video_on) three cycles earlier
// -----------------------------------------------------------------------------
module text_console_gen
    import text_console_pkg::*;
#(
    parameter int          COLS      = 40,
    parameter int          ROWS      = 20,
    parameter logic [11:0] FG_RGB    = 12'hFCF,
    parameter logic [11:0] BG_RGB    = 12'h000,
    parameter int          BLINK_DIV = 25_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     video_on,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    text_console_gen_if.slave        cif,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    input  logic                     clr_req,
    output logic                     busy,
    output logic [11:0]              rgb
);

    localparam logic [6:0] CX_MAX = 7'(COLS - 1);
    localparam logic [4:0] CY_MAX = 5'(ROWS - 1);
    localparam int         PX_B   = $clog2(TILE_W);
    localparam int         PY_B   = $clog2(TILE_H);
    localparam int         BW     = $clog2(BLINK_DIV);

    state_t              state;
    logic [6:0]          clr_col;
    logic [4:0]          clr_row;
    logic                clear_last;

    logic                accept, move_en, printable, is_bs, is_nl;
    logic [6:0]          cx, nx;
    logic [4:0]          cy, ny;
    logic                moved;

    logic                we;
    logic [RAM_AW-1:0]   wr_addr;
    logic [6:0]          wr_data;

    logic [BW-1:0]       blink_cnt;
    logic                blink_on;

    // Control decode: a clear request blocks the character port in the same
    // cycle, and a character offer blocks arrow pulses.
    assign cif.char_ready = (state == IDLE) && !clr_req;
    assign busy           = (state == CLEAR);
    assign accept         = cif.char_ready && cif.char_valid;
    assign move_en        = cif.char_ready && !cif.char_valid;
    assign printable      = is_printable(cif.char_data);
    assign is_bs          = (cif.char_data == CHR_BS);
    assign is_nl          = (cif.char_data == CHR_LF) || (cif.char_data == CHR_CR);
    assign clear_last     = busy && (clr_col == CX_MAX) && (clr_row == CY_MAX);

    // Backspace blanks the cell the cursor lands on, hence {ny, nx}.
    always_comb begin
        we      = 1'b0;
        wr_addr = {cy, cx};
        wr_data = CHR_SPACE;
        if (busy) begin
            we      = 1'b1;
            wr_addr = {clr_row, clr_col};
        end else if (accept && printable) begin
            we      = 1'b1;
            wr_data = cif.char_data;
        end else if (accept && is_bs) begin
            we      = 1'b1;
            wr_addr = {ny, nx};
        end
    end

    console_cursor_ctrl #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .home    (clear_last),
        .advance (accept && printable),
        .right   (move_en && right),
        .back    (accept && is_bs),
        .newline (accept && is_nl),
        .left    (move_en && left),
        .up      (move_en && up),
        .down    (move_en && down),
        .cx      (cx),
        .cy      (cy),
        .nx      (nx),
        .ny      (ny),
        .moved   (moved)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            clr_col <= 7'd0;
            clr_row <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_col <= 7'd0;
                        clr_row <= 5'd0;
                    end
                end
                CLEAR: begin
                    if (clr_col == CX_MAX) begin
                        clr_col <= 7'd0;
                        if (clr_row == CY_MAX) state <= IDLE;
                        else                   clr_row <= clr_row + 5'd1;
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Any activity restarts the blink phase with the cursor visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (moved || we) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    function automatic logic [11:0] pick_rgb(input logic vld, input logic in_range,
                                             input logic lit);
        if (!vld)      return 12'h000;
        if (!in_range) return BG_RGB;
        return lit ? FG_RGB : BG_RGB;
    endfunction

    logic [6:0]  ram_q;
    logic [7:0]  font_q;
    logic [9:0]  x_p0, y_p0, x_p1;
    logic [5:0]  row_p1;
    logic        vld_p0, vld_p1;
    logic        in_range, cursor_here, glyph_bit;

    dual_port_ram #(
        .ADDR_W (RAM_AW),
        .DATA_W (7)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .addr_a (wr_addr),
        .din_a  (wr_data),
        .addr_b ({y[8:4], x[9:3]}),
        .dout_b (ram_q)
    );

    ascii_rom u_rom (
        .clk  (clk),
        .addr ({ram_q, y_p0[PY_B-1:0]}),
        .data (font_q)
    );

    assign in_range    = (x_p1[9:3] < 7'(COLS)) && (row_p1 < 6'(ROWS));
    assign cursor_here = (x_p1[9:3] == cx) && (row_p1 == {1'b0, cy});
    assign glyph_bit   = font_q[~x_p1[PX_B-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_p0   <= '0;
            y_p0   <= '0;
            vld_p0 <= 1'b0;
            x_p1   <= '0;
            row_p1 <= '0;
            vld_p1 <= 1'b0;
            rgb    <= 12'h000;
        end else begin
            // p0: tile RAM read in flight
            x_p0   <= x;
            y_p0   <= y;
            vld_p0 <= video_on;
            // p1: glyph ROM read in flight
            x_p1   <= x_p0;
            row_p1 <= y_p0[9:4];
            vld_p1 <= vld_p0;
            // output: colour select, reverse video on the blinking cursor tile
            rgb    <= pick_rgb(vld_p1, in_range, glyph_bit ^ (cursor_here && blink_on));
        end
    end

endmodule

// File: doc/text_console_gen.md
Name: text_console_gen

Overview:
Parametrised successor to the fixed-size text tile generator. It drives a character console of COLS x ROWS 8x16 tiles on the 640x480 VGA pixel stream.
- Text arrives through a valid/ready character port with control-code handling: newline, carriage return, backspace.
- Four pre-debounced cursor-move pulses reposition the cursor.
- A hardware clear-screen engine, a blinking reverse-video cursor and configurable colours are included.
- It sits between the VGA sync counter (x, y, video_on) and the rgb output register feeding the DAC pins. It reuses the existing dual_port_ram (tile RAM) and ascii_rom.

Parameters:
COLS, 40, visible tile columns (1..80)
ROWS, 20, visible tile rows (1..30)
FG_RGB, 12'hFCF, glyph foreground colour
BG_RGB, 12'h000, background colour
BLINK_DIV, 25_000_000, clk cycles per cursor blink half-period (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
video_on  in  1  active-display flag from sync counter
x  in  10  current pixel column
y  in  10  current pixel row
char_valid  in  1  character offered
char_data  in  7  ASCII code
char_ready  out  1  character accepted when valid&ready
up, down, left, right  in  1 each  single-cycle debounced move pulses
clr_req  in  1  single-cycle clear-screen request
busy  out  1  clear in progress
rgb  out  12  pixel colour

Behaviour:
- Reset (async): cursor (0,0), FSM IDLE, blink_on=1, blink counter 0, pixel/video_on pipeline 0, rgb=0.
- Tile RAM address is {cy[4:0], cx[6:0]}. Read address is {y[8:4], x[9:3]}.
- Pixel pipeline:
  - RAM read takes 1 cycle, then ROM read 1 cycle, then the rgb register 1 cycle.
  - rgb corresponds to (x, y, video_on) sampled 3 cycles earlier.
  - x, y and video_on are delayed 3 stages; bit select is font_word[~x_d2[2:0]].
- Colour selection:
  - rgb = 0 when delayed video_on=0.
  - BG_RGB when the tile is outside COLS/ROWS.
  - Otherwise FG/BG by glyph bit, swapped (reverse) on the cursor tile when blink_on=1.
- FSM states: IDLE, CLEAR.
  - char_ready = (state==IDLE) & ~clr_req.
  - busy = (state==CLEAR).
- Priority in IDLE, per cycle: clr_req > char accept > move pulse. Lower-priority events in the same cycle are dropped, not queued.
- Accepted char:
  - 0x20..0x7E: write the code at the cursor, then advance the cursor.
  - 0x0A or 0x0D: cx=0, cy=cy+1 (ROWS-1 wraps to 0), no write.
  - 0x08: move the cursor back one cell, to (COLS-1, cy-1) when cx=0, and write 0x20 at the new position in the same cycle. At (0,0) the cursor stays and 0x20 is written at (0,0).
  - Other codes: accepted, no effect.
- Advance: cx+1. At cx=COLS-1, go to cx=0 and cy+1. At (COLS-1, ROWS-1), wrap to (0,0).
- Move pulses, each axis wrapping independently:
  - left at cx=0 gives COLS-1.
  - up at cy=0 gives ROWS-1.
  - down at ROWS-1 gives 0.
  - right behaves as advance, including row carry.
- CLEAR:
  - Entered on clr_req in IDLE.
  - Row/col counters write 0x20 to every visible cell, one per cycle, row-major from (0,0): COLS*ROWS cycles.
  - On the cycle after the final write: cursor (0,0), return to IDLE.
  - Move pulses and clr_req are ignored during CLEAR.
- Blink:
  - The counter runs 0..BLINK_DIV-1. At wrap it resets to 0 and toggles blink_on.
  - Any cursor change or RAM write forces counter=0 and blink_on=1.
- Reset asserted mid-CLEAR aborts the clear. RAM contents stay partially cleared; no RAM reset is implied.

Decomposition:
- Package text_console_pkg holds:
  - ASCII constants CHR_SPACE=7'h20, CHR_BS=7'h08, CHR_LF=7'h0A, CHR_CR=7'h0D, CHR_MIN=7'h20, CHR_MAX=7'h7E.
  - FSM state encoding (IDLE, CLEAR).
  - Tile geometry constants: TILE_W=8, TILE_H=16, RAM address width 12.
- Sub-module console_cursor_ctrl owns the cursor registers and wrap arithmetic. It takes advance/back/newline/left/right/up/down/home commands and outputs cx, cy and a moved flag.
- The top level contains the FSM, clear counters, blink, pixel pipeline and RAM/ROM instances.

Test Plan:
1. Reset, then send 0x41 with valid=1 -> ready=1 same cycle; RAM[{0,0}]=0x41; cursor (1,0); rgb for tile (0,0) shows the 'A' glyph in FCF with 3-cycle latency.
2. Cursor at (39,19) with defaults, send 0x42 -> written at addr {5'd19,7'd39}; cursor (0,0). Then send 0x0D at (5,3) -> cursor (0,4), no write.
3. Cursor (0,1), send 0x08 -> cursor (39,0), RAM[{0,39}]=0x20. At (0,0), send 0x08 -> cursor stays, RAM[0]=0x20.
4. clr_req pulse, then hold char_valid and toggle arrows -> busy=1 and ready=0 for exactly 800 cycles; all 800 cells=0x20; arrows ignored; cursor (0,0); ready=1 next cycle.
5. Simulate with BLINK_DIV=4 and no input -> cursor tile alternates reverse/normal every 4 cycles. A right pulse mid-phase gives blink_on=1 and counter 0 next cycle.
6. Pixel checks -> video_on=0 gives rgb=000 three cycles later; a pixel with x=330 (tile 41>=COLS) gives BG_RGB regardless of RAM content.
